// File: rtl/block_lock_ctrl_32b.sv
// 10GBASE-R block-lock controller: sync-header test windows, slip requests, block_lock.
// Optional hi_ber monitor compiled in with `define BLOCK_LOCK_HIBER_EN.
module block_lock_ctrl_32b #(
  parameter int unsigned SH_CNT_MAX   = 64,
  parameter int unsigned SH_INVLD_MAX = 16,
  parameter int unsigned SLIP_WAIT    = 66
`ifdef BLOCK_LOCK_HIBER_EN
  ,
  parameter int unsigned BER_WINDOW   = 40000,
  parameter int unsigned BER_THRESH   = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hdr,
  input  logic       hdr_vld,
  output logic       slip,
  output logic       block_lock,
  output logic       hi_ber,
  output logic [4:0] sh_invld_cnt
);

  localparam int unsigned SH_CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned INVLD_W  = 5;
  localparam int unsigned WAIT_W   = $clog2(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_RESET_CNT = 2'd0,
    ST_TEST_SH   = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } state_t;

  state_t               state;
  logic [SH_CNT_W-1:0]  sh_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 hdr_bad;
  logic [SH_CNT_W-1:0]  sh_cnt_inc;
  logic [INVLD_W-1:0]   invld_inc;

  // Post-increment counter values used by the window decision
  always_comb begin
    hdr_bad    = (hdr == 2'b00) || (hdr == 2'b11);
    sh_cnt_inc = sh_cnt + SH_CNT_W'(1);
    invld_inc  = sh_invld_cnt;
    if (hdr_bad && (sh_invld_cnt != {INVLD_W{1'b1}})) begin
      invld_inc = sh_invld_cnt + INVLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_RESET_CNT;
      sh_cnt       <= '0;
      wait_cnt     <= '0;
      sh_invld_cnt <= '0;
      slip         <= 1'b0;
      block_lock   <= 1'b0;
    end else begin
      slip <= 1'b0;
      unique case (state)
        ST_RESET_CNT: begin
          sh_cnt       <= '0;
          sh_invld_cnt <= '0;
          state        <= ST_TEST_SH;
        end
        ST_TEST_SH: begin
          if (hdr_vld) begin
            sh_cnt       <= sh_cnt_inc;
            sh_invld_cnt <= invld_inc;
            if (hdr_bad && !block_lock) begin
              slip     <= 1'b1;
              wait_cnt <= '0;
              state    <= ST_SLIP_WAIT;
            end else if (hdr_bad && (invld_inc == INVLD_W'(SH_INVLD_MAX))) begin
              block_lock <= 1'b0;
              slip       <= 1'b1;
              wait_cnt   <= '0;
              state      <= ST_SLIP_WAIT;
            end else if (sh_cnt_inc == SH_CNT_W'(SH_CNT_MAX)) begin
              if (invld_inc == '0) begin
                block_lock <= 1'b1;
              end
              state <= ST_RESET_CNT;
            end
          end
        end
        ST_SLIP_WAIT: begin
          // Headers are ignored while the aligner settles on the new boundary
          if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
            wait_cnt <= '0;
            state    <= ST_RESET_CNT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= ST_RESET_CNT;
      endcase
    end
  end

`ifdef BLOCK_LOCK_HIBER_EN
  localparam int unsigned WIN_W = $clog2(BER_WINDOW);
  localparam int unsigned BER_W = $clog2(BER_THRESH + 1);

  logic [WIN_W-1:0] win_cnt;
  logic [BER_W-1:0] ber_cnt;
  logic             ber_hit;
  logic             win_end;

  always_comb begin
    ber_hit = hdr_vld & hdr_bad;
    win_end = (win_cnt == WIN_W'(BER_WINDOW - 1));
  end

  // A hit on the window-end cycle seeds the next window's count
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_cnt <= '0;
      ber_cnt <= '0;
      hi_ber  <= 1'b0;
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
      if (!block_lock) begin
        ber_cnt <= '0;
        hi_ber  <= 1'b0;
      end else if (win_end) begin
        hi_ber  <= (ber_cnt >= BER_W'(BER_THRESH));
        ber_cnt <= BER_W'(ber_hit);
      end else if (ber_hit && (ber_cnt != BER_W'(BER_THRESH))) begin
        ber_cnt <= ber_cnt + BER_W'(1);
      end
    end
  end
`else
  assign hi_ber = 1'b0;
`endif

endmodule

// File: doc/block_lock_ctrl_32b.md
Name: block_lock_ctrl_32b

Overview:
- Clause 49 block-lock controller for the 10GBASE-R RX path.
- Sits after the 32b RX gearbox/aligner. Watches each 2-bit sync header the aligner delivers and decides whether the 66b block boundary is found.
- If the boundary is not found, it pulses a one-bit slip command back to the aligner and waits for the realigned stream.
- Drives block_lock to the descrambler/decoder. An optional hi_ber monitor can be compiled in.

Parameters:
- SH_CNT_MAX, 64: headers per test window.
- SH_INVLD_MAX, 16: invalid headers per window that force a slip while locked.
- SLIP_WAIT, 66: cycles after a slip pulse during which headers are ignored.
- BER_WINDOW, 40000: hi_ber window length in clk cycles (optional feature only).
- BER_THRESH, 16: invalid headers per window that assert hi_ber (optional feature only).

Ports:
- clk  in  1  RX recovered clock, shared with the aligner.
- rst  in  1  synchronous reset, active-low (0 = reset).
- hdr  in  2  sync header from the aligner (aligner ctrl output).
- hdr_vld  in  1  qualifies hdr for one cycle; driven as aligner dout_en & even.
- slip  out  1  one-cycle pulse requesting the aligner to shift the block boundary by 1 bit.
- block_lock  out  1  block boundary locked.
- hi_ber  out  1  high bit-error-rate indication; constant 0 when the optional feature is absent.
- sh_invld_cnt  out  5  invalid-header count in the current window, for status/debug.

Behaviour:
- Valid header: hdr == 2'b01 or 2'b10. Invalid header: 2'b00 or 2'b11.
- All outputs are registered. Reset (rst=0 at a clk edge) sets:
  - slip=0, block_lock=0, hi_ber=0, sh_invld_cnt=0;
  - internal sh_cnt=0, wait_cnt=0;
  - state=RESET_CNT.
- A reset mid-window or mid-slip-wait aborts it immediately.
- States: RESET_CNT, TEST_SH, SLIP_WAIT.
- RESET_CNT:
  - Clear sh_cnt and sh_invld_cnt.
  - block_lock is unchanged.
  - Go to TEST_SH next cycle.
  - hdr_vld in this cycle is ignored.
- TEST_SH, on each cycle with hdr_vld=1:
  - sh_cnt is incremented (7-bit, range 0..SH_CNT_MAX).
  - An invalid header also increments sh_invld_cnt (saturates at 31).
  - Decision uses the post-increment values, in priority order:
    1. Invalid header and block_lock=0 -> slip=1 next cycle; go to SLIP_WAIT.
    2. Invalid header and sh_invld_cnt == SH_INVLD_MAX -> block_lock=0, slip=1; go to SLIP_WAIT.
    3. sh_cnt == SH_CNT_MAX and sh_invld_cnt == 0 -> block_lock=1; go to RESET_CNT.
    4. sh_cnt == SH_CNT_MAX and sh_invld_cnt > 0 -> go to RESET_CNT (block_lock held).
    5. Otherwise stay in TEST_SH.
- TEST_SH with hdr_vld=0: no change.
- slip is high for exactly one cycle: the cycle after the deciding header.
- SLIP_WAIT:
  - wait_cnt counts 0..SLIP_WAIT-1; all hdr_vld are ignored.
  - At SLIP_WAIT-1, go to RESET_CNT.
  - No second slip is possible until a new window has started.
- Latency:
  - Deciding header (hdr_vld cycle N) -> block_lock/slip change at cycle N+1.
  - Unlocked acquisition with clean data = 64 valid headers, block_lock rises one cycle after the 64th.
- Locked operation:
  - Up to 15 invalid headers in a window keep lock; the window then restarts.
  - The 16th invalid header in the same window drops lock and slips.
- Back-to-back hdr_vld on consecutive cycles must be handled; no header may be dropped in TEST_SH.
- sh_invld_cnt output mirrors the internal counter; it reads 0 after a RESET_CNT cycle.

Optional Feature:
- Macro: BLOCK_LOCK_HIBER_EN.
- Defined:
  - Free-running window counter 0..BER_WINDOW-1, cleared by reset.
  - ber_cnt counts invalid headers (hdr_vld=1) while block_lock=1 (saturates at BER_THRESH).
  - At window end: hi_ber <= (ber_cnt >= BER_THRESH); ber_cnt cleared.
  - An invalid header landing on the window-end cycle counts toward the new window.
  - block_lock=0 forces ber_cnt=0 and hi_ber=0 next cycle.
- Undefined: window and ber logic absent; hi_ber tied 0.

Test Plan:
- Reset, then 64 hdr_vld with hdr=01 -> block_lock=1 one cycle after the 64th header; slip never pulses.
- Unlocked, hdr=11 on the 1st hdr_vld -> slip=1 for exactly 1 cycle; the next 66 cycles of hdr_vld are ignored; after that, 64 valid headers -> lock.
- Locked, window with 15 invalid (00) and 49 valid headers -> block_lock stays 1; sh_invld_cnt reads 15 then 0 after the window.
- Locked, 16 invalid headers within a window (16th at sh_cnt=40) -> block_lock=0 and slip=1 on the same cycle; 1 cycle wide.
- rst=0 asserted during SLIP_WAIT and while locked -> all outputs 0 next cycle; reacquisition needs 64 fresh valid headers.
- BLOCK_LOCK_HIBER_EN, BER_WINDOW=100, locked, 16 invalid headers spread over one window (no 16-in-64 slip) -> hi_ber=1 at window end; a clean next window -> hi_ber=0.
